inst_mem_resp: RTL and testbench
================================

# inst_mem_resp

Instruction-memory responder: the memory-side end of the core's instruction-fetch interface, standing in for the combinational ROM behind the RISC-V core. It accepts fetch requests through a valid/ready handshake and returns the 32-bit instruction after a configurable number of wait states. Misaligned and out-of-range fetches complete with an error flag and a NOP payload. A side loader port writes program words so the SoC can be booted without re-synthesis.

## Interface
- DEPTH_WORDS, 4096: memory depth in 32-bit words; power of two.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; DEPTH_WORDS*4 aligned.
- WAIT_CYCLES, 1: wait states between accept and response, range 0..15.
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_i  in  1  fetch request valid.
- req_addr_i  in  32  fetch byte address.
- req_ready_o  out  1  request accepted when req_valid_i && req_ready_o at a rising edge.
- rsp_valid_o  out  1  response valid, held until consumed.
- rsp_inst_o  out  32  instruction word.
- rsp_err_o  out  1  fetch fault (misaligned or out of range).
- rsp_ready_i  in  1  core consumes response when rsp_valid_o && rsp_ready_i.
- ld_we_i  in  1  loader write strobe.
- ld_addr_i  in  32  loader byte address; bits [1:0] ignored.
- ld_data_i  in  32  loader write data.

## Operation
- States: IDLE, WAIT, RESP. Reset value is IDLE.
- req_ready_o = !ld_we_i && (state==IDLE || (state==RESP && rsp_ready_i)). This is combinational from rsp_ready_i and ld_we_i.
- Accept in IDLE or RESP:
  - WAIT_CYCLES==0: latch the result and go to RESP.
  - Otherwise: load wait counter with WAIT_CYCLES, latch the address, and go to WAIT.
- WAIT: decrement the counter each cycle. When the counter equals 1, latch the result and go to RESP.
- RESP: rsp_valid_o=1. When rsp_ready_i=1 and there is no new accept, go to IDLE. A new accept in the same cycle follows the accept rule above (back-to-back).
- Result computation:
  - err = (addr[1:0]!=0) || addr<BASE_ADDR || addr>=BASE_ADDR+4*DEPTH_WORDS.
  - If err: rsp_inst_o=32'h0000_0013 (NOP) and rsp_err_o=1.
  - Else: rsp_inst_o=mem[(addr-BASE_ADDR)>>2] and rsp_err_o=0.
- Loader:
  - When ld_we_i=1 and ld_addr_i is in range, write mem[(ld_addr_i-BASE_ADDR)>>2] at the edge.
  - Out-of-range loader writes are dropped silently.
  - Writes are allowed in every state.
- Write-first bypass: if a loader write hits the same word in the cycle the result is latched, the latched instruction is ld_data_i.
- The memory array has no reset; its contents survive rst_n.
- rsp_inst_o and rsp_err_o are stable while rsp_valid_o=1 and the response is unconsumed.

## Timing
- Reset values: state IDLE, rsp_valid_o=0, rsp_inst_o=32'h0000_0013, rsp_err_o=0, counter 0. With ld_we_i=0, req_ready_o=1 right after reset release.
- Latency: for a request accepted at edge T, rsp_valid_o rises after edge T+WAIT_CYCLES, i.e. T+1+WAIT_CYCLES counted in response-visible cycles.
- Throughput:
  - WAIT_CYCLES==0 with rsp_ready_i held high: one fetch per cycle.
  - Otherwise: one fetch per WAIT_CYCLES+1 cycles.
- Backpressure: rsp_ready_i=0 in RESP holds the response indefinitely, and req_ready_o=0 meanwhile.
- Loader priority: ld_we_i=1 forces req_ready_o=0 that cycle. An in-flight request continues.
- Reset mid-operation: asserting rst_n low in WAIT or RESP clears the state asynchronously. The pending response is discarded and rsp_valid_o drops immediately.
- req_addr_i is sampled only at accept. Later changes do not affect the in-flight fetch.

## Test plan
- Load mem[0..3]=32'h00500093, 32'h00a00113, 32'h002081b3, 32'h0000006f. Fetch 0x0, 0x4, 0x8, 0xC with WAIT_CYCLES=1 and rsp_ready_i=1 -> the same words in order, rsp_err_o=0, each rsp_valid_o exactly 2 cycles after accept.
- WAIT_CYCLES=0, req_valid_i and rsp_ready_i held high, addresses 0x0..0xC -> responses on 4 consecutive cycles and req_ready_o constantly 1.
- Fetch 0x2, then fetch BASE_ADDR+4*DEPTH_WORDS -> both return rsp_inst_o=32'h00000013 with rsp_err_o=1.
- Hold rsp_ready_i=0 for 5 cycles in RESP -> rsp_valid_o=1 and rsp_inst_o unchanged throughout, req_ready_o=0. The response is consumed on the first cycle rsp_ready_i=1.
- Loader writes 32'hdeadbeef to 0x8 in the cycle a fetch of 0x8 latches its result -> rsp_inst_o=32'hdeadbeef. ld_we_i=1 while IDLE -> req_ready_o=0 that cycle.
- Drive rst_n low during WAIT -> rsp_valid_o=0 and rsp_inst_o=32'h00000013 immediately. After release a fetch of 0x0 returns the preloaded 32'h00500093 (memory retained).

Source files
------------

// File: rtl/inst_mem_resp.sv
// Instruction-memory responder: valid/ready fetch port with programmable wait states,
// fault reporting for misaligned/out-of-range fetches, and a side loader write port.
module inst_mem_resp #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  input  logic [31:0] req_addr_i,
  output logic        req_ready_o,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_inst_o,
  output logic        rsp_err_o,
  input  logic        rsp_ready_i,
  input  logic        ld_we_i,
  input  logic [31:0] ld_addr_i,
  input  logic [31:0] ld_data_i
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) << 2;
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic          latch_en;
  logic [31:0]   latch_addr;
  logic          accept;

  logic [32:0]   lat_diff, ld_diff;
  logic          lat_err, ld_hit, bypass;
  logic [AW-1:0] lat_idx, ld_idx;
  logic [31:0]   inst_q;
  logic          err_q;

  logic [31:0]   mem [DEPTH_WORDS];

  assign req_ready_o = !ld_we_i && (state_q == IDLE || (state_q == RESP && rsp_ready_i));
  assign accept      = req_valid_i && req_ready_o;
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_inst_o  = inst_q;
  assign rsp_err_o   = err_q;

  // 33-bit offsets so addresses below BASE_ADDR wrap to huge values and fail the span test
  assign lat_diff = {1'b0, latch_addr} - {1'b0, BASE_ADDR};
  assign lat_err  = (latch_addr[1:0] != 2'b00) || (lat_diff >= SPAN);
  assign lat_idx  = lat_diff[AW+1:2];

  assign ld_diff  = {1'b0, ld_addr_i} - {1'b0, BASE_ADDR};
  assign ld_hit   = (ld_diff < SPAN);
  assign ld_idx   = ld_diff[AW+1:2];
  assign bypass   = ld_we_i && ld_hit && (ld_idx == lat_idx);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    latch_en   = 1'b0;
    latch_addr = addr_q;
    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            latch_en   = 1'b1;
            latch_addr = req_addr_i;
            state_d    = RESP;
          end else begin
            cnt_d   = WAIT_INIT;
            addr_d  = req_addr_i;
            state_d = WAIT;
          end
        end else if (state_q == RESP && rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          latch_en = 1'b1;
          state_d  = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      inst_q  <= NOP;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      if (latch_en) begin
        err_q  <= lat_err;
        inst_q <= lat_err ? NOP : (bypass ? ld_data_i : mem[lat_idx]);
      end
    end
  end

  // Program storage deliberately has no reset so a loaded image survives rst_n
  always_ff @(posedge clk) begin
    if (ld_we_i && ld_hit) begin
      mem[ld_idx] <= ld_data_i;
    end
  end

endmodule

// File: tb/tb_inst_mem_resp.sv
// Scoreboard bench for inst_mem_resp: one instance with one wait state, one with none,
// sharing clock, reset and loader port.
module tb_inst_mem_resp;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_we;
  logic [31:0] ld_addr, ld_data;

  logic        req_valid, req_ready, rsp_valid, rsp_err, rsp_ready;
  logic [31:0] req_addr, rsp_inst;
  logic        req_valid0, req_ready0, rsp_valid0, rsp_err0, rsp_ready0;
  logic [31:0] req_addr0, rsp_inst0;

  int num_compared   = 0;
  int num_mismatched = 0;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  exp_t exp_q1[$];
  exp_t exp_q0[$];

  logic [31:0] prog [4] = '{32'h00500093, 32'h00a00113, 32'h002081b3, 32'h0000006f};

  always #5 clk = ~clk;

  inst_mem_resp #(.DEPTH_WORDS(4096), .BASE_ADDR(32'h0), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_ready_o(req_ready),
    .rsp_valid_o(rsp_valid), .rsp_inst_o(rsp_inst), .rsp_err_o(rsp_err), .rsp_ready_i(rsp_ready),
    .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data)
  );

  inst_mem_resp #(.DEPTH_WORDS(4096), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid0), .req_addr_i(req_addr0), .req_ready_o(req_ready0),
    .rsp_valid_o(rsp_valid0), .rsp_inst_o(rsp_inst0), .rsp_err_o(rsp_err0), .rsp_ready_i(rsp_ready0),
    .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    num_compared++;
    if (actual !== expected) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] exp_inst,
                               input logic exp_err, input bit push_exp);
    logic rdy;
    bit   accepted;
    accepted  = 1'b0;
    req_valid = 1'b1;
    req_addr  = addr;
    for (int i = 0; i < 50 && !accepted; i++) begin
      #1;
      rdy = req_ready;
      @(posedge clk);
      accepted = rdy;
    end
    #1;
    req_valid = 1'b0;
    req_addr  = 32'hffff_fff0;
    if (!accepted) begin
      num_compared++;
      num_mismatched++;
      $display("[TB] FAIL accept_timeout: addr %h not accepted, required accept within 50 cycles", addr);
    end else if (push_exp) begin
      exp_q1.push_back('{inst: exp_inst, err: exp_err});
    end
  endtask

  task automatic waitResp(output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        n = i;
        break;
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q1.size() == 0) begin
        num_compared++;
        num_mismatched++;
        $display("[TB] FAIL w1_unexpected_rsp: got inst %h, required no response", rsp_inst);
      end else begin
        e = exp_q1.pop_front();
        checkOutput("w1_inst", rsp_inst, e.inst);
        checkOutput("w1_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid0 && rsp_ready0) begin
      if (exp_q0.size() == 0) begin
        num_compared++;
        num_mismatched++;
        $display("[TB] FAIL w0_unexpected_rsp: got inst %h, required no response", rsp_inst0);
      end else begin
        e = exp_q0.pop_front();
        checkOutput("w0_inst", rsp_inst0, e.inst);
        checkOutput("w0_err", 32'(rsp_err0), 32'(e.err));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_addr   = 32'h0;
    rsp_ready  = 1'b1;
    req_valid0 = 1'b0;
    req_addr0  = 32'h0;
    rsp_ready0 = 1'b1;
    ld_we      = 1'b0;
    ld_addr    = 32'h0;
    ld_data    = 32'h0;

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_valid", 32'(rsp_valid), 0);
    checkOutput("rst_inst", rsp_inst, NOP);
    checkOutput("rst_err", 32'(rsp_err), 0);
    checkOutput("rst_valid0", 32'(rsp_valid0), 0);
    checkOutput("rst_inst0", rsp_inst0, NOP);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_ready", 32'(req_ready), 1);
    @(posedge clk); #1;

    // program load; loader strobe blocks requests
    for (int i = 0; i < 4; i++) begin
      ld_we   = 1'b1;
      ld_addr = 32'(i * 4);
      ld_data = prog[i];
      if (i == 0) begin
        @(negedge clk);
        checkOutput("ld_blocks_ready", 32'(req_ready), 0);
      end
      @(posedge clk); #1;
    end
    ld_we = 1'b0;

    // sequential fetches, one wait state
    for (int i = 0; i < 4; i++) begin
      applyStimulus(32'(i * 4), prog[i], 1'b0, 1'b1);
      waitResp(n);
      checkOutput("w1_latency", 32'(n), 2);
    end
    @(posedge clk); #1;

    // zero wait states, streaming
    req_valid0 = 1'b1;
    req_addr0  = 32'h0;
    exp_q0.push_back('{inst: prog[0], err: 1'b0});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("w0_req_ready", 32'(req_ready0), 1);
      if (i > 0) checkOutput("w0_stream_valid", 32'(rsp_valid0), 1);
      @(posedge clk); #1;
      if (i < 3) begin
        req_addr0 = 32'((i + 1) * 4);
        exp_q0.push_back('{inst: prog[i + 1], err: 1'b0});
      end else begin
        req_valid0 = 1'b0;
      end
    end
    @(negedge clk);
    checkOutput("w0_last_valid", 32'(rsp_valid0), 1);
    @(negedge clk);
    checkOutput("w0_idle_valid", 32'(rsp_valid0), 0);
    @(posedge clk); #1;

    // fault fetches
    applyStimulus(32'h0000_0002, NOP, 1'b1, 1'b1);
    waitResp(n);
    checkOutput("misalign_latency", 32'(n), 2);
    applyStimulus(32'h0000_4000, NOP, 1'b1, 1'b1);
    waitResp(n);
    checkOutput("oor_latency", 32'(n), 2);
    @(posedge clk); #1;

    // backpressure
    rsp_ready = 1'b0;
    applyStimulus(32'h4, prog[1], 1'b0, 1'b1);
    waitResp(n);
    checkOutput("bp_latency", 32'(n), 2);
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp_valid", 32'(rsp_valid), 1);
      checkOutput("bp_inst", rsp_inst, prog[1]);
      checkOutput("bp_req_ready", 32'(req_ready), 0);
      if (k < 4) @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("bp_released", 32'(rsp_valid), 0);

    // loader write hitting the word being latched
    @(posedge clk); #1;
    applyStimulus(32'h8, 32'hdeadbeef, 1'b0, 1'b1);
    ld_we   = 1'b1;
    ld_addr = 32'h8;
    ld_data = 32'hdeadbeef;
    waitResp(n);
    checkOutput("bypass_latency", 32'(n), 2);
    @(posedge clk); #1;
    ld_we = 1'b0;

    // loader strobe in IDLE; out-of-range write must be dropped
    ld_we   = 1'b1;
    ld_addr = 32'h0000_4000;
    ld_data = 32'hbad0bad0;
    @(negedge clk);
    checkOutput("idle_ld_ready", 32'(req_ready), 0);
    @(posedge clk); #1;
    ld_we = 1'b0;
    @(negedge clk);
    checkOutput("idle_ld_released", 32'(req_ready), 1);

    // reset during WAIT
    @(posedge clk); #1;
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_wait_valid", 32'(rsp_valid), 0);
    checkOutput("rst_wait_inst", rsp_inst, NOP);
    checkOutput("rst_wait_err", 32'(rsp_err), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_wait_no_rsp", 32'(rsp_valid), 0);

    // reset during RESP
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    applyStimulus(32'h4, 32'h0, 1'b0, 1'b0);
    waitResp(n);
    checkOutput("rst_resp_latency", 32'(n), 2);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_resp_valid", 32'(rsp_valid), 0);
    checkOutput("rst_resp_inst", rsp_inst, NOP);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("rst_resp_ready", 32'(req_ready), 1);

    // memory contents survive reset
    @(posedge clk); #1;
    applyStimulus(32'h0, prog[0], 1'b0, 1'b1);
    waitResp(n);
    checkOutput("retain_latency", 32'(n), 2);

    repeat (3) @(negedge clk);
    checkOutput("w1_queue_drained", 32'(exp_q1.size()), 0);
    checkOutput("w0_queue_drained", 32'(exp_q0.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
